// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising spike events over fixed windows and reports a
// rate/status result over a valid/ready handshake. Optional ISI timing via SPIKE_RATE_DECODER_ISI_EN.
module spike_rate_decoder #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int ISI_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             spike_in,
  output logic [7:0]       rate_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ISI_W-1:0] isi_out,
  output logic [1:0]       status
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  logic             spk_q;
  logic [WIN_W-1:0] win_cnt;
  logic [7:0]       evt_cnt;
  logic             sat;
  logic             evt;
  logic             close_win;
  logic             cnt_full;
  logic [7:0]       cnt_next;
  logic             sat_next;

  assign evt       = ena && spike_in && !spk_q;
  assign close_win = ena && (win_cnt == WIN_LAST);
  assign cnt_full  = (evt_cnt == 8'hFF);
  // Values as they would stand after this cycle, so a closing window includes its last event
  assign cnt_next  = (evt && !cnt_full) ? evt_cnt + 8'd1 : evt_cnt;
  assign sat_next  = sat || (evt && cnt_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk_q <= 1'b0;
    end else if (ena) begin
      spk_q <= spike_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      evt_cnt <= '0;
      sat     <= 1'b0;
    end else if (ena) begin
      if (close_win) begin
        win_cnt <= '0;
        evt_cnt <= '0;
        sat     <= 1'b0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        evt_cnt <= cnt_next;
        sat     <= sat_next;
      end
    end
  end

  // The handshake runs regardless of ena so a consumer can always drain the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_out  <= '0;
      status    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (close_win) begin
        rate_out  <= cnt_next;
        status[0] <= sat_next;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) begin
          status[1] <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SPIKE_RATE_DECODER_ISI_EN
  localparam logic WAIT_FIRST = 1'b0;
  localparam logic TIMING     = 1'b1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  logic             isi_state;
  logic [ISI_W-1:0] interval;
  logic [ISI_W-1:0] isi_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_state <= WAIT_FIRST;
      interval  <= '0;
      isi_reg   <= '0;
    end else if (ena) begin
      case (isi_state)
        WAIT_FIRST: begin
          if (evt) begin
            isi_state <= TIMING;
            interval  <= '0;
          end
        end
        TIMING: begin
          if (evt) begin
            isi_reg  <= (interval == ISI_MAX) ? ISI_MAX : interval + ISI_W'(1);
            interval <= '0;
          end else if (interval != ISI_MAX) begin
            interval <= interval + ISI_W'(1);
          end
        end
        default: isi_state <= WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_out <= '0;
    end else if (close_win) begin
      isi_out <= isi_reg;
    end
  end
`else
  assign isi_out = '0;
`endif

endmodule
